// File: rtl/pattern_gen_pkg.sv
// Shared encodings and LFSR helpers for the pattern burst generator.
// Imported by pattern_burst_next and pattern_burst_gen.
package pattern_gen_pkg;

    localparam logic [1:0] MODE_CNT   = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_WALK  = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Right-shift Galois masks for maximal-length polynomials.
    function automatic logic [63:0] lfsr_taps(input int width);
        logic [63:0] t;
        case (width)
            8:       t = 64'h0000_0000_0000_00B8;
            16:      t = 64'h0000_0000_0000_B400;
            32:      t = 64'h0000_0000_8020_0003;
            64:      t = 64'hD800_0000_0000_0000;
            default: t = 64'h0;
        endcase
        return t;
    endfunction

    // One Galois step; width-agnostic as long as taps fit the word.
    function automatic logic [63:0] lfsr_next(input logic [63:0] value,
                                              input logic [63:0] taps);
        return (value >> 1) ^ (value[0] ? taps : 64'h0);
    endfunction

endpackage

// File: rtl/pattern_burst_next.sv
// Combinational next-word logic: given the pattern mode and the
// word currently presented, produce the word that follows it.
module pattern_burst_next
    import pattern_gen_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] cur_i,
    output logic [DATA_W-1:0] nxt_o
);

    localparam logic [63:0] TAPS = lfsr_taps(DATA_W);

    // Select the successor word for the active pattern.
    always_comb begin
        nxt_o = cur_i;
        unique case (mode_i)
            MODE_CNT:   nxt_o = cur_i + DATA_W'(1);
            MODE_LFSR:  nxt_o = DATA_W'(lfsr_next(64'(cur_i), TAPS));
            MODE_WALK:  nxt_o = {cur_i[DATA_W-2:0], cur_i[DATA_W-1]};
            MODE_CONST: nxt_o = cur_i;
            default:    nxt_o = cur_i;
        endcase
    end

endmodule

// File: rtl/pattern_burst_gen.sv
// Triggered pattern burst source with a valid/ready output stream.
// Optional macro PATTERN_BURST_GEN_LAST_EN adds a last_out marker.
module pattern_burst_gen
    import pattern_gen_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          LEN_W     = 16,
    parameter logic [63:0] LFSR_SEED = 64'd1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              trigger_in,
    input  logic [1:0]        mode_in,
    input  logic [LEN_W-1:0]  burst_len_in,
    input  logic [DATA_W-1:0] start_value_in,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              busy_out,
`ifdef PATTERN_BURST_GEN_LAST_EN
    output logic              done_out,
    output logic              last_out
`else
    output logic              done_out
`endif
);

    localparam logic [DATA_W-1:0] SEED_T   = DATA_W'(LFSR_SEED);
    localparam logic [DATA_W-1:0] SEED_EFF =
        (SEED_T == '0) ? DATA_W'(1) : SEED_T;

    logic              trig_prev_q;
    logic              tick_q;
    state_e            state_q;
    logic [1:0]        mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] start_q;
    logic [DATA_W-1:0] lfsr_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] first_d;
    logic [DATA_W-1:0] word_d;
`ifdef PATTERN_BURST_GEN_LAST_EN
    logic              last_q;
`endif

    pattern_burst_next #(
        .DATA_W (DATA_W)
    ) u_next (
        .mode_i (mode_q),
        .cur_i  (data_q),
        .nxt_o  (word_d)
    );

    // Register the trigger and form a one-cycle rising-edge tick.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            trig_prev_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            trig_prev_q <= trigger_in;
            tick_q      <= trigger_in & ~trig_prev_q;
        end
    end

    // First word of a burst for the latched mode.
    always_comb begin
        first_d = start_q;
        unique case (mode_q)
            MODE_CNT:   first_d = start_q;
            MODE_LFSR:  first_d = lfsr_q;
            MODE_WALK:  first_d = DATA_W'(1);
            MODE_CONST: first_d = start_q;
            default:    first_d = start_q;
        endcase
    end

    // Burst FSM with registered stream outputs and LFSR state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_CNT;
            len_q   <= '0;
            start_q <= '0;
            lfsr_q  <= SEED_EFF;
            data_q  <= '1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PATTERN_BURST_GEN_LAST_EN
            last_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (tick_q) begin
                        mode_q  <= mode_in;
                        len_q   <= burst_len_in;
                        start_q <= start_value_in;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (len_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        data_q  <= first_d;
                        valid_q <= 1'b1;
`ifdef PATTERN_BURST_GEN_LAST_EN
                        last_q  <= (len_q == LEN_W'(1));
`endif
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (valid_q && ready_in) begin
                        // LFSR advances with every beat so the next
                        // burst resumes where this one stopped.
                        if (mode_q == MODE_LFSR) begin
                            lfsr_q <= word_d;
                        end
                        if (len_q == LEN_W'(1)) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
`ifdef PATTERN_BURST_GEN_LAST_EN
                            last_q  <= 1'b0;
`endif
                            state_q <= ST_IDLE;
                        end else begin
                            data_q <= word_d;
                            len_q  <= len_q - LEN_W'(1);
`ifdef PATTERN_BURST_GEN_LAST_EN
                            last_q <= (len_q == LEN_W'(2));
`endif
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign busy_out  = busy_q;
    assign done_out  = done_q;
`ifdef PATTERN_BURST_GEN_LAST_EN
    assign last_out  = last_q;
`endif

endmodule
